wb_demux3: RTL and testbench
============================

Name: wb_demux3

Overview:
- Registered 1-to-3 result distributor; the inverse of the 3-input select muxes.
- Takes one result stream (data + dest register + 2-bit select) and steers each beat to exactly one of three consumer channels:
  - ch0: GPR file write port
  - ch1: HI/LO unit
  - ch2: CP0
- Sits between the EX/MEM result path and the writeback consumers.
- One holding stage; valid/ready handshake on every side.

Parameters:
- DW, 32, data width of result and outputs
- AW, 5, destination register index width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush; discards the held beat
- in_valid  in  1  upstream beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  DW  result value
- in_dest  in  AW  destination register index
- in_sel  in  2  target channel: 0, 1, 2; 3 is illegal
- outN_valid  out  1  channel N (N=0..2) holds a beat
- outN_ready  in  1  channel N consumer accepts
- outN_data  out  DW  held data; driven to all three channels, only the valid one is meaningful
- outN_dest  out  AW  held dest; driven to all three channels
- sel_err  out  1  one-cycle pulse on acceptance of in_sel==3
- sel_err_sticky  out  1  set on any sel_err; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - State EMPTY.
  - All outN_valid=0; held data/dest/sel=0.
  - sel_err=0, sel_err_sticky=0.
  - in_ready=0 while rst_n=0.
- States:
  - EMPTY: nothing held.
  - HOLD: one beat held with its sel.
- Output valids:
  - outN_valid=1 only in HOLD with held sel==N; at most one valid asserted at any time.
  - Held beat retires when out[sel]_ready=1.
- in_ready (combinational):
  - Equals !flush && (EMPTY || out[held_sel]_ready).
  - Gives full throughput: one beat per cycle when the consumer is always ready.
- Latency: beat accepted at edge k is presented on its channel from cycle k+1.
- Transitions:
  - EMPTY, accept legal beat -> HOLD.
  - HOLD, retire, no accept -> EMPTY.
  - HOLD, retire and accept same cycle -> HOLD with new beat; may switch channel with no bubble.
  - HOLD, no retire -> HOLD; data, dest and sel stable, in_ready=0.
  - Accept of in_sel==3 -> beat dropped, state unchanged after any retire, sel_err=1 next cycle, sticky set.
  - An illegal beat is never presented on any channel and never stalls.
- Flush:
  - flush=1 at an edge -> EMPTY; held beat discarded; no outN_valid the next cycle.
  - in_ready=0 during flush, so a simultaneous in_valid is not accepted.
  - Flush has priority over retire and accept.
- Consumer behaviour: ready on a non-selected channel is ignored; a consumer may hold ready low indefinitely, and the beat stays stable.
- Reset mid-transfer: held beat lost; outputs return to reset values immediately (async).
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: WB_DEMUX_STATS_EN.
- When defined:
  - Adds outputs cnt0, cnt1, cnt2 (16 bits each) and err_cnt (8 bits).
  - cntN increments on each retire of channel N.
  - err_cnt increments on each sel_err.
  - All counters wrap modulo their width, reset to 0 on rst_n, and are unaffected by flush.
  - Flushed beats are not counted.
- When undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - channel-select constants SEL_GPR=0, SEL_HILO=1, SEL_CP0=2, SEL_BAD=3
  - state encoding for EMPTY/HOLD
  - default DW/AW
- Natural sub-module: wb_hold_reg.
  - One-entry register slot with load/clear.
  - Instantiated once; the top adds channel decode, in_ready, error and stats logic.

Test Plan:
- Reset release, then sel=0, data=0x00400030, dest=5, out0_ready=1 -> out0_valid high next cycle with data 0x00400030, dest 5; out1/out2 valid stay 0.
- Back-to-back streaming, all readies=1:
  - sel sequence 0,1,2,0 with data 1,2,3,4.
  - Expect one retire per cycle on channels 0,1,2,0 in order, no bubbles, in_ready constantly 1.
- Backpressure:
  - sel=2, data=0xDEADBEEF, out2_ready=0 for 3 cycles.
  - Expect in_ready=0 and out2_data stable for those 3 cycles; retire on the cycle out2_ready=1.
  - out0_ready/out1_ready toggling during the stall has no effect.
- Illegal select:
  - in_sel=3 accepted -> sel_err pulses exactly 1 cycle and sel_err_sticky=1.
  - No channel valid; the following legal beat passes normally.
- Flush:
  - Flush while holding sel=1 beat with out1_ready=0, and in_valid=1 in the same cycle.
  - Expect next cycle all valids 0 and the new beat not accepted (in_ready=0 during flush).
- Async reset mid-hold: rst_n low between clock edges -> all valids 0 immediately. With WB_DEMUX_STATS_EN, counters read 0 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared channel-select codes, state encoding and default widths for wb_demux3.
package wb_pkg;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam logic [1:0] SEL_GPR  = 2'd0;
    localparam logic [1:0] SEL_HILO = 2'd1;
    localparam logic [1:0] SEL_CP0  = 2'd2;
    localparam logic [1:0] SEL_BAD  = 2'd3;
    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;
endpackage

// File: rtl/wb_demux3_if.sv
// wb_demux3_if: upstream result stream plus the three consumer channels of wb_demux3.
interface wb_demux3_if #(parameter int DW = 32, parameter int AW = 5);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_dest;
    logic [1:0]    in_sel;
    logic          out0_valid, out1_valid, out2_valid;
    logic          out0_ready, out1_ready, out2_ready;
    logic [DW-1:0] out0_data, out1_data, out2_data;
    logic [AW-1:0] out0_dest, out1_dest, out2_dest;
    modport slave (
        input  in_valid, in_data, in_dest, in_sel,
        output in_ready,
        output out0_valid, out1_valid, out2_valid,
        input  out0_ready, out1_ready, out2_ready,
        output out0_data, out1_data, out2_data,
        output out0_dest, out1_dest, out2_dest
    );
    modport master (
        output in_valid, in_data, in_dest, in_sel,
        input  in_ready,
        input  out0_valid, out1_valid, out2_valid,
        output out0_ready, out1_ready, out2_ready,
        input  out0_data, out1_data, out2_data,
        input  out0_dest, out1_dest, out2_dest
    );
endinterface

// File: rtl/wb_hold_reg.sv
// wb_hold_reg: one-entry slot for data/dest/sel; clear wins over load.
module wb_hold_reg #(parameter int DW = 32, parameter int AW = 5) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_dest,
    input  logic [1:0]    in_sel,
    output logic [DW-1:0] data_q,
    output logic [AW-1:0] dest_q,
    output logic [1:0]    sel_q
);
    logic [DW-1:0] data_d;
    logic [AW-1:0] dest_d;
    logic [1:0]    sel_d;
    always_comb begin
        data_d = clear ? '0 : load ? in_data : data_q;
        dest_d = clear ? '0 : load ? in_dest : dest_q;
        sel_d  = clear ? '0 : load ? in_sel  : sel_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dest_q <= '0;
            sel_q  <= '0;
        end else begin
            data_q <= data_d;
            dest_q <= dest_d;
            sel_q  <= sel_d;
        end
    end
endmodule

// File: rtl/wb_demux3.sv
// wb_demux3: registered 1-to-3 result distributor (GPR / HI-LO / CP0) with valid/ready on every side.
// Define WB_DEMUX_STATS_EN to add per-channel retire counters and an illegal-select counter.
module wb_demux3 import wb_pkg::*; #(parameter int DW = DW_DEF, parameter int AW = AW_DEF) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    wb_demux3_if.slave     bus,
    output logic           sel_err,
    output logic           sel_err_sticky
`ifdef WB_DEMUX_STATS_EN
    ,
    output logic [15:0]    cnt0,
    output logic [15:0]    cnt1,
    output logic [15:0]    cnt2,
    output logic [7:0]     err_cnt
`endif
);
    state_e        state_q, state_d;
    logic [DW-1:0] data_q;
    logic [AW-1:0] dest_q;
    logic [1:0]    sel_q;
    logic [3:0]    rdy;
    logic          retire, accept, load;
    logic          sel_err_q, sel_err_d, sticky_q, sticky_d;
    // bit 3 pads the illegal code so indexing by sel_q is always in range
    assign rdy          = {1'b0, bus.out2_ready, bus.out1_ready, bus.out0_ready};
    assign retire       = state_q == HOLD && rdy[sel_q];
    assign bus.in_ready = rst_n && !flush && (state_q == EMPTY || retire);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept && bus.in_sel != SEL_BAD;
    always_comb begin
        sel_err_d = accept && bus.in_sel == SEL_BAD;
        sticky_d  = sticky_q | sel_err_d;
        state_d   = flush ? EMPTY : load ? HOLD : retire ? EMPTY : state_q;
    end
    wb_hold_reg #(.DW(DW), .AW(AW)) u_hold (
        .clk(clk), .rst_n(rst_n), .load(load), .clear(flush),
        .in_data(bus.in_data), .in_dest(bus.in_dest), .in_sel(bus.in_sel),
        .data_q(data_q), .dest_q(dest_q), .sel_q(sel_q)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            sel_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_err_q <= sel_err_d;
            sticky_q  <= sticky_d;
        end
    end
    assign bus.out0_valid = state_q == HOLD && sel_q == SEL_GPR;
    assign bus.out1_valid = state_q == HOLD && sel_q == SEL_HILO;
    assign bus.out2_valid = state_q == HOLD && sel_q == SEL_CP0;
    assign bus.out0_data  = data_q;
    assign bus.out1_data  = data_q;
    assign bus.out2_data  = data_q;
    assign bus.out0_dest  = dest_q;
    assign bus.out1_dest  = dest_q;
    assign bus.out2_dest  = dest_q;
    assign sel_err        = sel_err_q;
    assign sel_err_sticky = sticky_q;
`ifdef WB_DEMUX_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [7:0]  err_q, err_d;
    logic        ret_ok;
    // a flush in the retire cycle discards the beat, so it is not counted
    assign ret_ok = retire && !flush;
    always_comb begin
        cnt0_d = cnt0_q + 16'(ret_ok && sel_q == SEL_GPR);
        cnt1_d = cnt1_q + 16'(ret_ok && sel_q == SEL_HILO);
        cnt2_d = cnt2_q + 16'(ret_ok && sel_q == SEL_CP0);
        err_d  = err_q + 8'(sel_err_d);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            cnt2_q <= '0;
            err_q  <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
            err_q  <= err_d;
        end
    end
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;
    assign cnt2    = cnt2_q;
    assign err_cnt = err_q;
`endif
endmodule

// File: tb/tb_wb_demux3.sv
// tb_wb_demux3: directed self-checking bench for wb_demux3 (stats checks when WB_DEMUX_STATS_EN is defined).
module tb_wb_demux3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic sel_err, sel_err_sticky;
    int   n_chk = 0;
    int   n_fail = 0;
    wb_demux3_if #(.DW(32), .AW(5)) bus ();
    logic [2:0] vld;
    assign vld = {bus.out2_valid, bus.out1_valid, bus.out0_valid};
`ifdef WB_DEMUX_STATS_EN
    logic [15:0] cnt0, cnt1, cnt2;
    logic [7:0]  err_cnt;
`endif
    wb_demux3 #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
        .sel_err(sel_err), .sel_err_sticky(sel_err_sticky)
`ifdef WB_DEMUX_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .err_cnt(err_cnt)
`endif
    );
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.in_valid = 0; bus.in_data = '0; bus.in_dest = '0; bus.in_sel = '0;
        bus.out0_ready = 0; bus.out1_ready = 0; bus.out2_ready = 0;
        bus.in_valid = 1;
        #2;
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL reset_valids got %b want 000", vld); end
        n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_chk++; if ({sel_err, sel_err_sticky} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", {sel_err, sel_err_sticky}); end
        n_chk++; if (bus.out0_data !== 32'h0 || bus.out0_dest !== 5'd0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", bus.out0_data, bus.out0_dest); end
        bus.in_valid = 0;
        tick(); tick();
        rst_n = 1;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic;
        bus.in_valid = 1; bus.in_sel = 2'd0; bus.in_data = 32'h00400030; bus.in_dest = 5'd5;
        bus.out0_ready = 1;
        tick();
        bus.in_valid = 0;
        n_chk++; if (vld !== 3'b001) begin n_fail++; $display("FAIL basic_valids got %b want 001", vld); end
        n_chk++; if (bus.out0_data !== 32'h00400030) begin n_fail++; $display("FAIL basic_data got %h want 00400030", bus.out0_data); end
        n_chk++; if (bus.out0_dest !== 5'd5) begin n_fail++; $display("FAIL basic_dest got %0d want 5", bus.out0_dest); end
        tick();
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL basic_retire got %b want 000", vld); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        bus.out0_ready = 1; bus.out1_ready = 1; bus.out2_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1; bus.in_sel = seq[i]; bus.in_data = 32'(i + 1); bus.in_dest = 5'(i + 10);
            @(negedge clk);
            n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
            tick();
            n_chk++; if (vld !== 3'(1 << seq[i])) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want %b", i, vld, 3'(1 << seq[i])); end
            n_chk++; if (bus.out1_data !== 32'(i + 1) || bus.out2_dest !== 5'(i + 10)) begin n_fail++; $display("FAIL b2b_data[%0d] got %h/%0d want %h/%0d", i, bus.out1_data, bus.out2_dest, i + 1, i + 10); end
        end
        bus.in_valid = 0;
        tick();
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL b2b_drain got %b want 000", vld); end
    endtask

    task automatic test_backpressure;
        bus.out2_ready = 0;
        bus.in_valid = 1; bus.in_sel = 2'd2; bus.in_data = 32'hDEADBEEF; bus.in_dest = 5'd7;
        tick();
        bus.in_sel = 2'd0; bus.in_data = 32'h00000011; bus.in_dest = 5'd3;
        for (int i = 0; i < 3; i++) begin
            bus.out0_ready = i[0]; bus.out1_ready = ~i[0];
            @(negedge clk);
            n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
            n_chk++; if (vld !== 3'b100 || bus.out2_data !== 32'hDEADBEEF || bus.out2_dest !== 5'd7) begin n_fail++; $display("FAIL bp_hold[%0d] got %b %h want 100 deadbeef", i, vld, bus.out2_data); end
            tick();
        end
        bus.out2_ready = 1; bus.out0_ready = 0;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        n_chk++; if (vld !== 3'b001 || bus.out0_data !== 32'h00000011 || bus.out0_dest !== 5'd3) begin n_fail++; $display("FAIL bp_next got %b %h want 001 00000011", vld, bus.out0_data); end
        bus.out0_ready = 1;
        tick();
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL bp_drain got %b want 000", vld); end
    endtask

    task automatic test_illegal;
        bus.out0_ready = 1; bus.out1_ready = 1; bus.out2_ready = 1;
        bus.in_valid = 1; bus.in_sel = 2'd3; bus.in_data = 32'h99; bus.in_dest = 5'd1;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_in_ready got %b want 1", bus.in_ready); end
        n_chk++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL ill_err_early got %b want 0", sel_err); end
        tick();
        bus.in_sel = 2'd1; bus.in_data = 32'h55; bus.in_dest = 5'd2;
        n_chk++; if (sel_err !== 1'b1 || sel_err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_err got %b%b want 11", sel_err, sel_err_sticky); end
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL ill_valids got %b want 000", vld); end
        tick();
        bus.in_valid = 0;
        n_chk++; if (sel_err !== 1'b0 || sel_err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got %b%b want 01", sel_err, sel_err_sticky); end
        n_chk++; if (vld !== 3'b010 || bus.out1_data !== 32'h55) begin n_fail++; $display("FAIL ill_next got %b %h want 010 00000055", vld, bus.out1_data); end
        tick();
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL ill_drain got %b want 000", vld); end
    endtask

    task automatic test_flush;
        bus.out1_ready = 0;
        bus.in_valid = 1; bus.in_sel = 2'd1; bus.in_data = 32'hAA; bus.in_dest = 5'd4;
        tick();
        flush = 1; bus.in_sel = 2'd0; bus.in_data = 32'hBB;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b0 || vld !== 3'b010) begin n_fail++; $display("FAIL flush_during got %b %b want 0 010", bus.in_ready, vld); end
        tick();
        flush = 0; bus.in_valid = 0;
        n_chk++; if (vld !== 3'b000) begin n_fail++; $display("FAIL flush_after got %b want 000", vld); end
        tick();
        n_chk++; if (vld !== 3'b000 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_noaccept got %b %b want 000 1", vld, bus.in_ready); end
        bus.out1_ready = 1;
    endtask

    task automatic test_async_reset;
`ifdef WB_DEMUX_STATS_EN
        n_chk++; if ({cnt0, cnt1, cnt2, err_cnt} !== {16'd4, 16'd2, 16'd2, 8'd1}) begin n_fail++; $display("FAIL stats got %0d %0d %0d %0d want 4 2 2 1", cnt0, cnt1, cnt2, err_cnt); end
`endif
        bus.out0_ready = 0;
        bus.in_valid = 1; bus.in_sel = 2'd0; bus.in_data = 32'h1234; bus.in_dest = 5'd9;
        tick();
        bus.in_valid = 0;
        n_chk++; if (vld !== 3'b001) begin n_fail++; $display("FAIL ar_hold got %b want 001", vld); end
        #2 rst_n = 0;
        #1;
        n_chk++; if (vld !== 3'b000 || bus.in_ready !== 1'b0 || sel_err_sticky !== 1'b0) begin n_fail++; $display("FAIL ar_async got %b %b %b want 000 0 0", vld, bus.in_ready, sel_err_sticky); end
        tick();
        rst_n = 1;
        tick();
        n_chk++; if (vld !== 3'b000 || bus.out0_data !== 32'h0) begin n_fail++; $display("FAIL ar_release got %b %h want 000 0", vld, bus.out0_data); end
`ifdef WB_DEMUX_STATS_EN
        n_chk++; if ({cnt0, cnt1, cnt2, err_cnt} !== '0) begin n_fail++; $display("FAIL stats_reset got %0d %0d %0d %0d want 0", cnt0, cnt1, cnt2, err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
